// File: rtl/kcounter_filter_pkg.sv
// -----------------------------------------------------------------------------
// kcounter_pkg
// Shared definitions for the K-counter loop filter:
//   - default parameter values for WIDTH and LOCK_CYCLES
//   - the lock-detector FSM state encoding
// -----------------------------------------------------------------------------
package kcounter_pkg;

  // Default counter width (signed two's complement), legal range 4..16.
  localparam int DEFAULT_WIDTH       = 8;

  // Default number of consecutive quiet enabled cycles that declares lock,
  // legal range 2..65535.
  localparam int DEFAULT_LOCK_CYCLES = 64;

  // Lock-detector states.
  //   DISABLED : filter not running, quiet count held at zero
  //   ACQUIRE  : running, counting quiet cycles towards lock
  //   LOCKED   : quiet for at least LOCK_CYCLES cycles
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage : kcounter_pkg

// File: rtl/kcounter_filter_lock_detector.sv
// -----------------------------------------------------------------------------
// lock_detector
// Counts consecutive quiet enabled cycles (no carry/borrow, no reload) and
// declares lock once LOCK_CYCLES of them have been seen in a row.
//
// Ports:
//   clk_i     in  1  clock, rising edge
//   reset_i   in  1  asynchronous, active-high reset
//   enable_i  in  1  filter run enable; low forces DISABLED
//   event_i   in  1  carry or borrow being produced on this edge
//   clear_i   in  1  counter reload; restarts acquisition
//   locked_o  out 1  registered lock indication, high only in LOCKED
//
// event_i must be the *next-state* pulse (the value the pulse registers are
// about to load), so that locked_o falls on the same edge carry/borrow rise.
// -----------------------------------------------------------------------------
module lock_detector
  import kcounter_pkg::*;
#(
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic event_i,
  input  logic clear_i,
  output logic locked_o
);

  // Wide enough to hold LOCK_CYCLES itself; the count saturates there.
  localparam int             QW          = $clog2(LOCK_CYCLES + 1);
  localparam logic [QW-1:0]  LOCK_TARGET = QW'(LOCK_CYCLES);
  localparam logic [QW-1:0]  QUIET_ONE   = QW'(1);

  lock_state_t    state_q;
  logic [QW-1:0]  quiet_q;
  logic [QW-1:0]  quiet_inc;

  // Saturating increment of the quiet count.
  assign quiet_inc = (quiet_q == LOCK_TARGET) ? quiet_q : quiet_q + QUIET_ONE;

  // Single registered FSM. locked_o is a flop, not a decode of state_q.
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= DISABLED;
      quiet_q  <= '0;
      locked_o <= 1'b0;
    end else if (!enable_i) begin
      state_q  <= DISABLED;
      quiet_q  <= '0;
      locked_o <= 1'b0;
    end else if (clear_i || event_i) begin
      // A reload or a carry/borrow breaks the quiet streak from any state.
      state_q  <= ACQUIRE;
      quiet_q  <= '0;
      locked_o <= 1'b0;
    end else begin
      quiet_q <= quiet_inc;
      case (state_q)
        DISABLED, ACQUIRE: begin
          // The first enabled cycle out of DISABLED already counts as quiet.
          if (quiet_inc >= LOCK_TARGET) begin
            state_q  <= LOCKED;
            locked_o <= 1'b1;
          end else begin
            state_q  <= ACQUIRE;
            locked_o <= 1'b0;
          end
        end
        LOCKED: begin
          state_q  <= LOCKED;
          locked_o <= 1'b1;
        end
        default: begin
          state_q  <= DISABLED;
          quiet_q  <= '0;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : lock_detector

// File: rtl/kcounter_filter.sv
// -----------------------------------------------------------------------------
// kcounter_filter
// Signed up/down K-counter loop filter for a digital PLL. Steps the counter by
// one per lead/lag request; on reaching +K or -K it reloads the (saturated)
// initial value and emits a one-cycle carry or borrow pulse. A lock detector
// reports lock after LOCK_CYCLES consecutive pulse-free enabled cycles.
//
// Ports:
//   clk_i           in  1      clock, rising edge
//   reset_i         in  1      asynchronous, active-high reset
//   enable_i        in  1      filter run enable
//   increment_i     in  1      phase-lead step request
//   decrement_i     in  1      phase-lag step request
//   load_i          in  1      force reload of the initial value
//   modulus_i       in  WIDTH  unsigned threshold K (clamped to 1..2^(W-1)-1)
//   initialValue_i  in  WIDTH  signed reload value (saturated to +/-(K-1))
//   value_o         out WIDTH  signed registered counter value
//   carry_o         out 1      one-cycle pulse when +K is reached
//   borrow_o        out 1      one-cycle pulse when -K is reached
//   locked_o        out 1      registered lock indication
// -----------------------------------------------------------------------------
module kcounter_filter
  import kcounter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    increment_i,
  input  logic                    decrement_i,
  input  logic                    load_i,
  input  logic        [WIDTH-1:0] modulus_i,
  input  logic signed [WIDTH-1:0] initialValue_i,
  output logic signed [WIDTH-1:0] value_o,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    locked_o
);

  // Threshold arithmetic is done one bit wider than the counter so that +K,
  // -K and the unsigned modulus all compare correctly as signed numbers.
  localparam int                    K_MAX_INT = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [WIDTH:0] K_MAX     = (WIDTH + 1)'(K_MAX_INT);
  localparam logic signed [WIDTH:0] ONE_X     = (WIDTH + 1)'(1);
  localparam logic signed [WIDTH-1:0] ONE_W   = WIDTH'(1);

  logic signed [WIDTH:0]   mod_x;
  logic signed [WIDTH:0]   k_eff;
  logic signed [WIDTH:0]   k_m1;
  logic signed [WIDTH:0]   init_x;
  logic signed [WIDTH:0]   reload_x;
  logic signed [WIDTH-1:0] reload_w;
  logic signed [WIDTH:0]   cnt_x;
  logic                    step_up;
  logic                    step_dn;
  logic signed [WIDTH-1:0] value_next;
  logic                    carry_next;
  logic                    borrow_next;

  assign step_up = increment_i & ~decrement_i;
  assign step_dn = decrement_i & ~increment_i;

  // Effective K and saturated reload value R. Both follow the inputs
  // combinationally, so a change lands on the very next edge.
  always_comb begin
    mod_x  = {1'b0, modulus_i};
    init_x = {initialValue_i[WIDTH-1], initialValue_i};
    cnt_x  = {value_o[WIDTH-1], value_o};

    if (mod_x == '0) begin
      k_eff = ONE_X;
    end else if (mod_x > K_MAX) begin
      k_eff = K_MAX;
    end else begin
      k_eff = mod_x;
    end

    k_m1 = k_eff - ONE_X;

    if (init_x > k_m1) begin
      reload_x = k_m1;
    end else if (init_x < -k_m1) begin
      reload_x = -k_m1;
    end else begin
      reload_x = init_x;
    end

    // reload_x is within +/-(K-1), so it always fits the counter width.
    reload_w = reload_x[WIDTH-1:0];
  end

  // Next counter value and pulses, in strict priority order.
  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    value_next  = value_o;
    carry_next  = 1'b0;
    borrow_next = 1'b0;

    if (load_i) begin
      value_next = reload_w;
    end else if (!enable_i) begin
      value_next = value_o;
    end else if ((cnt_x >= k_eff) || (cnt_x <= -k_eff)) begin
      // Modulus shrank below the current value: resynchronise silently.
      value_next = reload_w;
    end else if (step_up && (cnt_x == k_m1)) begin
      value_next = reload_w;
      carry_next = 1'b1;
    end else if (step_dn && (cnt_x == -k_m1)) begin
      value_next  = reload_w;
      borrow_next = 1'b1;
    end else if (step_up) begin
      value_next = value_o + ONE_W;
    end else if (step_dn) begin
      value_next = value_o - ONE_W;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      value_o  <= '0;
      carry_o  <= 1'b0;
      borrow_o <= 1'b0;
    end else begin
      value_o  <= value_next;
      carry_o  <= carry_next;
      borrow_o <= borrow_next;
    end
  end

  // The detector sees the pulse about to be registered, so lock drops on the
  // same edge the carry/borrow rises.
  lock_detector #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_detector (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .event_i  (carry_next | borrow_next),
    .clear_i  (load_i),
    .locked_o (locked_o)
  );

endmodule : kcounter_filter
